wbm: RTL and testbench

Writeback stage of the ECAP5-DPROC pipeline, directly downstream of the execute stage. It consumes the execute stage's result stream (write enable, destination register, 32-bit result) through a valid/ready handshake. Results are buffered in a small in-order queue and committed to the register-file write port, which can stall. The stage provides a forwarding lookup for buffered, not-yet-committed results and maintains the 64-bit retired-instruction counter.

---
 rtl/wbm.sv | 112 +++++++++++
 tb/tb_wbm.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbm.sv
// wbm: writeback stage. Buffers execute-stage results in an in-order queue,
//      commits them to the register-file write port, forwards pending writes
//      and counts retired instructions.
// Latency: a result accepted into an empty queue is presented on reg_write_o
//          the next cycle. Backpressure: input_ready_o drops when the queue is
//          full, and is derived from registered state only (no ready-to-ready path).
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   input_valid_i / input_ready_o     result handshake from execute
//   result_write_i/_addr_i/result_i   result fields (write enable, rd, value)
//   reg_write_o/_waddr_o/_wdata_o     register-file write request (head entry)
//   reg_write_ready_i                 register file accepts the write
//   fwd_addr_i / fwd_hit_o/_data_o    lookup of buffered, uncommitted writes
//   instret_o                         64-bit retired-instruction counter
module wbm #(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        input_valid_i,
    output logic        input_ready_o,
    input  logic        result_write_i,
    input  logic [4:0]  result_addr_i,
    input  logic [31:0] result_i,
    output logic        reg_write_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    input  logic        reg_write_ready_i,
    input  logic [4:0]  fwd_addr_i,
    output logic        fwd_hit_o,
    output logic [31:0] fwd_data_o,
    output logic [63:0] instret_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic        ent_write [DEPTH];
    logic [4:0]  ent_addr  [DEPTH];
    logic [31:0] ent_data  [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [63:0]   instret;

    logic head_needs;
    logic accept;
    logic retire;

    // Writes to x0 are architecturally dropped, so such entries never
    // request the register file and retire without waiting for it.
    assign head_needs    = ent_write[rd_ptr] && (ent_addr[rd_ptr] != 5'd0);
    assign input_ready_o = (count != FULL);
    assign accept        = input_valid_i && input_ready_o;
    assign retire        = (count != '0) && (!head_needs || reg_write_ready_i);

    assign reg_write_o = (count != '0) && head_needs;
    assign reg_waddr_o = reg_write_o ? ent_addr[rd_ptr] : 5'd0;
    assign reg_wdata_o = reg_write_o ? ent_data[rd_ptr] : 32'd0;
    assign instret_o   = instret;

    // Scan from oldest to youngest; a later match overwrites an earlier one,
    // so the youngest pending write wins. Entries addressing x0 never match
    // because they do not need a write.
    logic [AW-1:0] scan_idx;
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = 32'd0;
        scan_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr + AW'(i);
            if (((AW+1)'(i) < count) && ent_write[scan_idx] &&
                (ent_addr[scan_idx] != 5'd0) &&
                (ent_addr[scan_idx] == fwd_addr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = ent_data[scan_idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            instret <= 64'd0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_write[i] <= 1'b0;
                ent_addr[i]  <= 5'd0;
                ent_data[i]  <= 32'd0;
            end
        end else begin
            if (accept) begin
                ent_write[wr_ptr] <= result_write_i;
                ent_addr[wr_ptr]  <= result_addr_i;
                ent_data[wr_ptr]  <= result_i;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (retire) begin
                rd_ptr  <= rd_ptr + AW'(1);
                instret <= instret + 64'd1;
            end
            case ({accept, retire})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_wbm.sv
module tb_wbm;

    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        input_valid_i;
    logic        input_ready_o;
    logic        result_write_i;
    logic [4:0]  result_addr_i;
    logic [31:0] result_i;
    logic        reg_write_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        reg_write_ready_i;
    logic [4:0]  fwd_addr_i;
    logic        fwd_hit_o;
    logic [31:0] fwd_data_o;
    logic [63:0] instret_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic [63:0] m_instret;

    wbm #(.DEPTH(DEPTH)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .input_valid_i     (input_valid_i),
        .input_ready_o     (input_ready_o),
        .result_write_i    (result_write_i),
        .result_addr_i     (result_addr_i),
        .result_i          (result_i),
        .reg_write_o       (reg_write_o),
        .reg_waddr_o       (reg_waddr_o),
        .reg_wdata_o       (reg_wdata_o),
        .reg_write_ready_i (reg_write_ready_i),
        .fwd_addr_i        (fwd_addr_i),
        .fwd_hit_o         (fwd_hit_o),
        .fwd_data_o        (fwd_data_o),
        .instret_o         (instret_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic w, input logic [4:0] a, input logic [31:0] d);
        input_valid_i  = 1'b1;
        result_write_i = w;
        result_addr_i  = a;
        result_i       = d;
    endtask

    function automatic logic needs(input ent_t e);
        return e.w && (e.a != 5'd0);
    endfunction

    initial begin
        logic        m_ret;
        logic        m_acc;
        logic        e_hit;
        logic [31:0] e_fdat;
        ent_t        ne;

        rst_i = 1'b1;
        input_valid_i = 1'b0;
        result_write_i = 1'b0;
        result_addr_i = 5'd0;
        result_i = 32'd0;
        reg_write_ready_i = 1'b0;
        fwd_addr_i = 5'd0;
        tick();
        tick();
        rst_i = 1'b0;

        // Reset state
        chk("rst_in_rdy", input_ready_o, 1);
        chk("rst_wr", reg_write_o, 0);
        chk("rst_waddr", reg_waddr_o, 0);
        chk("rst_wdata", reg_wdata_o, 0);
        chk("rst_fhit", fwd_hit_o, 0);
        chk("rst_fdata", fwd_data_o, 0);
        chk("rst_instret", instret_o, 0);

        // Single result, one-cycle latency, head visible to forwarding
        reg_write_ready_i = 1'b1;
        push(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        input_valid_i = 1'b0;
        fwd_addr_i = 5'd5;
        #1;
        chk("t1_wr", reg_write_o, 1);
        chk("t1_waddr", reg_waddr_o, 5);
        chk("t1_wdata", reg_wdata_o, 32'hDEADBEEF);
        chk("t1_fhit_head", fwd_hit_o, 1);
        chk("t1_fdata_head", fwd_data_o, 32'hDEADBEEF);
        chk("t1_instret0", instret_o, 0);
        tick();
        chk("t1_wr_after", reg_write_o, 0);
        chk("t1_waddr_after", reg_waddr_o, 0);
        chk("t1_fhit_after", fwd_hit_o, 0);
        chk("t1_instret1", instret_o, 1);

        // x0 write and non-writing result retire without the register file
        reg_write_ready_i = 1'b0;
        push(1'b1, 5'd0, 32'h123);
        tick();
        chk("t2_wr_x0", reg_write_o, 0);
        chk("t2_waddr_x0", reg_waddr_o, 0);
        push(1'b0, 5'd7, 32'h456);
        tick();
        input_valid_i = 1'b0;
        chk("t2_wr_nowr", reg_write_o, 0);
        chk("t2_instret_a", instret_o, 2);
        tick();
        chk("t2_wr_end", reg_write_o, 0);
        chk("t2_instret_b", instret_o, 3);

        // Full queue, stall, then ordered drain
        push(1'b1, 5'd3, 32'h11);
        tick();
        chk("t3_rdy_one", input_ready_o, 1);
        chk("t3_waddr_a", reg_waddr_o, 3);
        push(1'b1, 5'd4, 32'h22);
        tick();
        chk("t3_rdy_full", input_ready_o, 0);
        chk("t3_wr_stall", reg_write_o, 1);
        push(1'b1, 5'd6, 32'h33);
        tick();
        chk("t3_rdy_still_full", input_ready_o, 0);
        chk("t3_waddr_hold", reg_waddr_o, 3);
        chk("t3_wdata_hold", reg_wdata_o, 32'h11);
        chk("t3_instret_hold", instret_o, 3);
        reg_write_ready_i = 1'b1;
        tick();
        chk("t3_rdy_back", input_ready_o, 1);
        chk("t3_waddr_b", reg_waddr_o, 4);
        chk("t3_wdata_b", reg_wdata_o, 32'h22);
        chk("t3_instret_c", instret_o, 4);
        tick();
        input_valid_i = 1'b0;
        chk("t3_waddr_c", reg_waddr_o, 6);
        chk("t3_wdata_c", reg_wdata_o, 32'h33);
        chk("t3_instret_d", instret_o, 5);
        tick();
        chk("t3_wr_empty", reg_write_o, 0);
        chk("t3_instret_e", instret_o, 6);

        // Forwarding: youngest match wins, incoming entry not visible
        reg_write_ready_i = 1'b0;
        push(1'b1, 5'd9, 32'hA);
        tick();
        push(1'b1, 5'd9, 32'hB);
        fwd_addr_i = 5'd9;
        #1;
        chk("t4_fdata_noinput", fwd_data_o, 32'hA);
        tick();
        input_valid_i = 1'b0;
        chk("t4_fhit", fwd_hit_o, 1);
        chk("t4_fdata_young", fwd_data_o, 32'hB);
        fwd_addr_i = 5'd0;
        #1;
        chk("t4_fhit_x0", fwd_hit_o, 0);
        chk("t4_fdata_x0", fwd_data_o, 0);
        fwd_addr_i = 5'd2;
        #1;
        chk("t4_fhit_miss", fwd_hit_o, 0);
        chk("t4_fdata_miss", fwd_data_o, 0);

        // Reset with a full, stalled queue discards everything
        fwd_addr_i = 5'd9;
        push(1'b1, 5'd12, 32'hC);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        input_valid_i = 1'b0;
        chk("t6_rdy", input_ready_o, 1);
        chk("t6_wr", reg_write_o, 0);
        chk("t6_instret", instret_o, 0);
        chk("t6_fhit", fwd_hit_o, 0);
        reg_write_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_wr_drain", reg_write_o, 0);
            chk("t6_instret_drain", instret_o, 0);
        end

        // Streaming against a reference queue; first half ready=1 and
        // valid=1 throughout, second half with random valid/ready
        q.delete();
        m_instret = 64'd0;
        for (int i = 0; i < 1000; i++) begin
            input_valid_i     = (i < 500) ? 1'b1 : 1'($urandom_range(0, 1));
            reg_write_ready_i = (i < 500) ? 1'b1 : 1'($urandom_range(0, 1));
            result_write_i    = 1'($urandom_range(0, 3) != 0);
            result_addr_i     = 5'($urandom_range(0, 7));
            result_i          = $urandom;
            fwd_addr_i        = 5'($urandom_range(0, 7));
            m_ret = (q.size() != 0) && (!needs(q[0]) || reg_write_ready_i);
            m_acc = input_valid_i && (q.size() != DEPTH);
            ne.w = result_write_i;
            ne.a = result_addr_i;
            ne.d = result_i;
            tick();
            if (m_ret) begin
                void'(q.pop_front());
                m_instret = m_instret + 64'd1;
            end
            if (m_acc) q.push_back(ne);
            e_hit = 1'b0;
            e_fdat = 32'd0;
            foreach (q[k]) begin
                if (needs(q[k]) && q[k].a == fwd_addr_i) begin
                    e_hit = 1'b1;
                    e_fdat = q[k].d;
                end
            end
            if (q.size() != 0 && needs(q[0])) begin
                chk("s_wr", reg_write_o, 1);
                chk("s_waddr", reg_waddr_o, q[0].a);
                chk("s_wdata", reg_wdata_o, q[0].d);
            end else begin
                chk("s_wr_idle", reg_write_o, 0);
                chk("s_waddr_idle", reg_waddr_o, 0);
            end
            chk("s_rdy", input_ready_o, q.size() != DEPTH);
            chk("s_fhit", fwd_hit_o, e_hit);
            chk("s_fdata", fwd_data_o, e_fdat);
            chk("s_instret", instret_o, m_instret);
        end

        input_valid_i = 1'b0;
        reg_write_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (q.size() != 0) begin
                void'(q.pop_front());
                m_instret = m_instret + 64'd1;
            end
            tick();
        end
        chk("s_drain_wr", reg_write_o, 0);
        chk("s_drain_instret", instret_o, m_instret);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
